// File: rtl/dmem_lsu.sv
// Load/store unit between the memory stage and a word-only synchronous-read
// data memory. Handles byte/half/word loads with lane extraction and sign or
// zero extension, does read-modify-write for sub-word stores, and reports
// misaligned, out-of-range or reserved-size requests without a memory access.
module dmem_lsu #(
   parameter int unsigned MEM_BYTES = 32'd8192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_WAIT = 3'd1;
   localparam logic [2:0] S_RD_DATA = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_ERR     = 3'd4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q,  size_d;
   logic        we_q,    we_d;
   logic        uns_q,   uns_d;

   logic        req_bad;
   logic [31:0] merged;
   logic [31:0] load_data;
   logic [7:0]  load_byte;
   logic [15:0] load_half;

   // Classify the incoming request as an error before it is accepted.
   always_comb begin
      req_bad = 1'b0;
      case (req_size)
         SZ_BYTE: req_bad = 1'b0;
         SZ_HALF: req_bad = req_addr[0];
         SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
         default: req_bad = 1'b1;
      endcase
      if (req_addr >= MEM_BYTES) req_bad = 1'b1;
   end

   // Replace the addressed lane of the fetched word with the store data.
   always_comb begin
      merged = mem_rd;
      if (size_q == SZ_HALF) begin
         if (addr_q[1]) merged[31:16] = wdata_q[15:0];
         else           merged[15:0]  = wdata_q[15:0];
      end else begin
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
   end

   // Pick the addressed lane of the fetched word and extend it to 32 bits.
   always_comb begin
      load_byte = mem_rd[{addr_q[1:0], 3'b000} +: 8];
      load_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
      case (size_q)
         SZ_BYTE: load_data = {{24{~uns_q & load_byte[7]}}, load_byte};
         SZ_HALF: load_data = {{16{~uns_q & load_half[15]}}, load_half};
         default: load_data = mem_rd;
      endcase
   end

   // Next-state logic: request capture, sequencing and the RMW merge.
   always_comb begin
      // NOTE: every signal gets a default up front so no path leaves it unassigned and infers a latch.
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      we_d    = we_q;
      uns_d   = uns_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               size_d  = req_size;
               we_d    = req_we;
               uns_d   = req_unsigned;
               if (req_bad)                           state_d = S_ERR;
               else if (req_we && req_size == SZ_WORD) state_d = S_WRITE;
               else                                   state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: state_d = S_RD_DATA;
         S_RD_DATA: begin
            if (we_q) begin
               wdata_d = merged;
               state_d = S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and request registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
      end
   end

   // Responses and memory writes are gated by rst_n so an interrupted RMW
   // neither writes nor answers.
   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = rst_n & ((state_q == S_WRITE) || (state_q == S_ERR) ||
                                ((state_q == S_RD_DATA) && !we_q));
   assign resp_err   = rst_n & (state_q == S_ERR);
   assign resp_rdata = (rst_n && state_q == S_RD_DATA && !we_q) ? load_data : 32'h0;
   assign mem_we     = rst_n & (state_q == S_WRITE);
   assign mem_a      = {addr_q[31:2], 2'b00};
   assign mem_wd     = wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a 2048 x 32 synchronous-read memory model.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;

   int n_vec = 0;
   int n_err = 0;
   int wr_count = 0;

   logic [31:0] mem [0:2047];

   dmem_lsu #(.MEM_BYTES(8192)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory model and write counter.
   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         mem[mem_a[12:2]] <= mem_wd;
         wr_count <= wr_count + 1;
      end
      mem_rd <= mem[mem_a[12:2]];
   end

   // Issue one request (called just after a rising edge) and capture the response.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic hs_ready, output int lat,
                        output logic [31:0] rdata, output logic err,
                        output logic we_r, output logic [31:0] a_r,
                        output logic [31:0] wd_r, output int writes);
      int w0;
      w0 = wr_count;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      hs_ready = req_ready;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      lat = -1; rdata = '0; err = 1'b0; we_r = 1'b0; a_r = '0; wd_r = '0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            lat = c; rdata = resp_rdata; err = resp_err;
            we_r = mem_we; a_r = mem_a; wd_r = mem_wd;
            break;
         end
      end
      @(posedge clk); #1;
      writes = wr_count - w0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      n_vec++; if ({resp_valid, resp_err, mem_we} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {resp_valid, resp_err, mem_we}); end
      n_vec++; if ({resp_rdata, mem_a, mem_wd} !== 96'h0) begin n_err++; $display("FAIL reset_buses got %h %h %h exp 0", resp_rdata, mem_a, mem_wd); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_word_store_load();
      logic hs, err, we_r; int lat, wr; logic [31:0] rd, a_r, wd_r;
      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, hs, lat, rd, err, we_r, a_r, wd_r, wr);
      n_vec++; if (hs !== 1'b1) begin n_err++; $display("FAIL wst_ready got %b exp 1", hs); end
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL wst_latency got %0d exp 1", lat); end
      n_vec++; if ({we_r, a_r, wd_r, err} !== {1'b1, 32'h100, 32'hDEADBEEF, 1'b0}) begin n_err++; $display("FAIL wst_write got we=%b a=%h wd=%h err=%b exp we=1 a=00000100 wd=deadbeef err=0", we_r, a_r, wd_r, err); end
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL wst_rdata got %h exp 0", rd); end
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, hs, lat, rd, err, we_r, a_r, wd_r, wr);
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL wld_latency got %0d exp 2", lat); end
      n_vec++; if ({rd, err} !== {32'hDEADBEEF, 1'b0}) begin n_err++; $display("FAIL wld_data got %h err=%b exp deadbeef err=0", rd, err); end
      n_vec++; if (wr !== 0) begin n_err++; $display("FAIL wld_nowrite got %0d writes exp 0", wr); end
   endtask

   task automatic test_byte_store_rmw();
      logic hs, err, we_r; int lat, wr; logic [31:0] rd, a_r, wd_r;
      issue(1'b1, 2'b00, 1'b0, 32'h102, 32'h1234565A, hs, lat, rd, err, we_r, a_r, wd_r, wr);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL bst_latency got %0d exp 3", lat); end
      n_vec++; if ({we_r, a_r, wd_r} !== {1'b1, 32'h100, 32'hDE5ABEEF}) begin n_err++; $display("FAIL bst_write got we=%b a=%h wd=%h exp we=1 a=00000100 wd=de5abeef", we_r, a_r, wd_r); end
      n_vec++; if (wr !== 1) begin n_err++; $display("FAIL bst_writes got %0d exp 1", wr); end
      n_vec++; if (mem[11'h040] !== 32'hDE5ABEEF) begin n_err++; $display("FAIL bst_mem got %h exp de5abeef", mem[11'h040]); end
   endtask

   task automatic test_extension();
      logic        t_uns  [6];
      logic [1:0]  t_size [6];
      logic [31:0] t_addr [6];
      logic [31:0] t_exp  [6];
      logic hs, err, we_r; int lat, wr; logic [31:0] rd, a_r, wd_r;
      t_uns[0] = 1'b0; t_size[0] = 2'b00; t_addr[0] = 32'h103; t_exp[0] = 32'hFFFFFFDE;
      t_uns[1] = 1'b1; t_size[1] = 2'b00; t_addr[1] = 32'h103; t_exp[1] = 32'h000000DE;
      t_uns[2] = 1'b0; t_size[2] = 2'b01; t_addr[2] = 32'h100; t_exp[2] = 32'hFFFFBEEF;
      t_uns[3] = 1'b1; t_size[3] = 2'b01; t_addr[3] = 32'h102; t_exp[3] = 32'h0000DE5A;
      t_uns[4] = 1'b0; t_size[4] = 2'b00; t_addr[4] = 32'h102; t_exp[4] = 32'h0000005A;
      t_uns[5] = 1'b0; t_size[5] = 2'b00; t_addr[5] = 32'h101; t_exp[5] = 32'hFFFFFFBE;
      for (int i = 0; i < 6; i++) begin
         issue(1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, hs, lat, rd, err, we_r, a_r, wd_r, wr);
         n_vec++;
         if ({lat == 2, rd, err} !== {1'b1, t_exp[i], 1'b0}) begin
            n_err++;
            $display("FAIL ext_%0d got lat=%0d data=%h err=%b exp lat=2 data=%h err=0", i, lat, rd, err, t_exp[i]);
         end
      end
   endtask

   task automatic test_errors();
      logic        t_we   [5];
      logic [1:0]  t_size [5];
      logic [31:0] t_addr [5];
      logic hs, err, we_r; int lat, wr; logic [31:0] rd, a_r, wd_r;
      t_we[0] = 1'b0; t_size[0] = 2'b01; t_addr[0] = 32'h101;
      t_we[1] = 1'b0; t_size[1] = 2'b10; t_addr[1] = 32'h102;
      t_we[2] = 1'b0; t_size[2] = 2'b10; t_addr[2] = 32'h2000;
      t_we[3] = 1'b0; t_size[3] = 2'b11; t_addr[3] = 32'h100;
      t_we[4] = 1'b1; t_size[4] = 2'b10; t_addr[4] = 32'h2000;
      for (int i = 0; i < 5; i++) begin
         issue(t_we[i], t_size[i], 1'b0, t_addr[i], 32'hCAFEF00D, hs, lat, rd, err, we_r, a_r, wd_r, wr);
         n_vec++;
         if ({lat == 1, err, rd, we_r, wr == 0} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL err_%0d got lat=%0d err=%b data=%h we=%b writes=%0d exp lat=1 err=1 data=0 we=0 writes=0", i, lat, err, rd, we_r, wr);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  t_size [3];
      logic        t_uns  [3];
      logic [31:0] t_addr [3];
      logic [31:0] t_exp  [3];
      int acc_cyc [3];
      int rsp_cyc [3];
      logic [31:0] rsp_dat [3];
      int n_acc, n_rsp, ready_hi;
      logic took;
      t_size[0] = 2'b10; t_uns[0] = 1'b0; t_addr[0] = 32'h100; t_exp[0] = 32'hDE5ABEEF;
      t_size[1] = 2'b00; t_uns[1] = 1'b1; t_addr[1] = 32'h103; t_exp[1] = 32'h000000DE;
      t_size[2] = 2'b01; t_uns[2] = 1'b0; t_addr[2] = 32'h102; t_exp[2] = 32'hFFFFDE5A;
      for (int i = 0; i < 3; i++) begin acc_cyc[i] = -1; rsp_cyc[i] = -1; rsp_dat[i] = '0; end
      n_acc = 0; n_rsp = 0; ready_hi = 0;
      req_valid = 1'b1; req_we = 1'b0; req_wdata = '0;
      req_size = t_size[0]; req_unsigned = t_uns[0]; req_addr = t_addr[0];
      for (int cyc = 0; cyc < 9; cyc++) begin
         @(negedge clk);
         took = 1'b0;
         if (req_ready === 1'b1) ready_hi++;
         if (req_ready === 1'b1 && req_valid && n_acc < 3) begin
            acc_cyc[n_acc] = cyc; took = 1'b1;
         end
         if (resp_valid === 1'b1 && n_rsp < 3) begin
            rsp_cyc[n_rsp] = cyc; rsp_dat[n_rsp] = resp_rdata; n_rsp++;
         end
         @(posedge clk); #1;
         if (took) begin
            n_acc++;
            if (n_acc < 3) begin
               req_size = t_size[n_acc]; req_unsigned = t_uns[n_acc]; req_addr = t_addr[n_acc];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if ({acc_cyc[i], rsp_cyc[i]} !== {3 * i, 3 * i + 2}) begin
            n_err++;
            $display("FAIL b2b_timing_%0d got acc=%0d rsp=%0d exp acc=%0d rsp=%0d", i, acc_cyc[i], rsp_cyc[i], 3 * i, 3 * i + 2);
         end
         n_vec++;
         if (rsp_dat[i] !== t_exp[i]) begin
            n_err++;
            $display("FAIL b2b_data_%0d got %h exp %h", i, rsp_dat[i], t_exp[i]);
         end
      end
      n_vec++; if (ready_hi !== 3) begin n_err++; $display("FAIL b2b_ready_cycles got %0d exp 3", ready_hi); end
   endtask

   task automatic test_reset_mid_rmw();
      int w0;
      logic hs, err, we_r; int lat, wr; logic [31:0] rd, a_r, wd_r;
      w0 = wr_count;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 32'h202; req_wdata = 32'h0000ABCD;
      @(posedge clk); #1;                    // accepted -> RD_WAIT
      req_valid = 1'b0;
      @(posedge clk); #1;                    // now in RD_DATA, WRITE is next
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_vec++;
         if ({mem_we, resp_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_rmw_quiet_%0d got we=%b rv=%b exp 00", i, mem_we, resp_valid);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if ({req_ready, resp_valid} !== 2'b10) begin n_err++; $display("FAIL rst_rmw_after got ready=%b rv=%b exp 10", req_ready, resp_valid); end
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (wr_count - w0 !== 0) begin n_err++; $display("FAIL rst_rmw_writes got %0d exp 0", wr_count - w0); end
      issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, hs, lat, rd, err, we_r, a_r, wd_r, wr);
      n_vec++; if ({lat == 2, rd} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL rst_rmw_mem got lat=%0d data=%h exp lat=2 data=0", lat, rd); end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      mem_rd = 32'h0;
      test_reset();
      test_word_store_load();
      test_byte_store_rmw();
      test_extension();
      test_errors();
      test_back_to_back();
      test_reset_mid_rmw();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the datapath's memory stage and the word-only data memory (synchronous-read RAM, 2048 x 32-bit, word index = byte address[12:2]).
- Accepts byte, halfword and word loads and stores from the core.
- Performs lane extraction and sign/zero extension on loads, and read-modify-write for sub-word stores.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 8192, size of the data memory in bytes; any address >= MEM_BYTES is out of range.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is reserved and treated as an error.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/half data is in the low bits.
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_err  out  1  valid with resp_valid: misaligned, out of range, or reserved size.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- mem_we  out  1  write enable to the data memory.
- mem_a  out  32  word-aligned byte address {addr_q[31:2], 2'b00}.
- mem_wd  out  32  write data to the data memory.
- mem_rd  in  32  read data; valid in the cycle after the address was presented for one full cycle (registered RAM output).

Behaviour:
- States: IDLE, RD_WAIT, RD_DATA, WRITE, ERR.
- Reset (rst_n low at a clock edge):
  - state -> IDLE; addr_q, wdata_q, size_q, we_q, uns_q all -> 0.
  - Outputs: req_ready = 1 (after the edge), resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_we = 0, mem_a = 0, mem_wd = 0.
  - mem_we is gated by rst_n, so no memory write occurs in any cycle where rst_n is low. A read-modify-write interrupted by reset is abandoned with no write and no response.
- IDLE:
  - req_ready = 1. A handshake occurs when req_valid & req_ready; all request fields are latched.
  - Error condition: size 11; or half with addr[0] != 0; or word with addr[1:0] != 00; or addr >= MEM_BYTES. On error -> ERR.
  - Otherwise, word store -> WRITE; wdata_q = req_wdata.
  - Otherwise, load or sub-word store -> RD_WAIT.
- RD_WAIT: mem_a driven from addr_q, mem_we = 0; -> RD_DATA.
- RD_DATA: mem_rd is valid.
  - Load: select the lane with addr_q[1:0] (little-endian). Byte lane k = bits [8k+7:8k]; half lane = bits [15:0] or [31:16]. Extend to 32 bits per uns_q. Set resp_valid = 1, resp_err = 0; -> IDLE.
  - Sub-word store: wdata_q = mem_rd with the addressed byte/half lane replaced by req_wdata[7:0] or [15:0]; -> WRITE.
- WRITE: mem_we = 1, mem_wd = wdata_q, mem_a from addr_q; resp_valid = 1, resp_rdata = 0; -> IDLE.
- ERR: resp_valid = 1, resp_err = 1, resp_rdata = 0, no memory access; -> IDLE.
- Latency, counting the handshake cycle as 0:
  - word store: resp in cycle 1.
  - load: resp in cycle 2.
  - sub-word store: resp in cycle 3.
  - error: resp in cycle 1.
- Throughput:
  - req_ready is 0 in every non-IDLE state, so the response cycle cannot accept a new request.
  - The next request is accepted in the cycle after resp_valid.
  - Back-to-back requests therefore have no overlap and no ordering hazard.
- mem_wd = wdata_q in all states; it is only meaningful while mem_we = 1.
- req_valid held high while req_ready = 0 is ignored; no request is queued.

Test Plan:
- Reset: hold rst_n low 2 cycles mid-RMW (state WRITE pending) -> mem_we never high, req_ready = 1 and resp_valid = 0 after release.
- Word store then load: store 0xDEADBEEF @0x100 -> mem_we = 1 in cycle 1 with mem_a = 0x100. Load word @0x100 -> resp_rdata = 0xDEADBEEF in cycle 2.
- Byte store RMW: memory @0x100 = 0xDEADBEEF; store byte 0x5A @0x102 -> mem_wd = 0xDE5ABEEF with mem_we in cycle 3; no other write occurs.
- Sign/zero extension on @0x100 = 0xDE5ABEEF:
  - signed byte @0x103 -> 0xFFFFFFDE.
  - unsigned byte @0x103 -> 0x000000DE.
  - signed half @0x100 -> 0xFFFFBEEF.
  - unsigned half @0x102 -> 0x0000DE5A.
- Errors -> each gives resp_err = 1 in cycle 1 and mem_we never high:
  - half @0x101.
  - word @0x102.
  - word @0x2000 (= MEM_BYTES).
  - size 11.
- Back-to-back: req_valid held high with three loads -> accepted exactly every 3 cycles, req_ready = 0 during RD_WAIT/RD_DATA, responses in order.
